// File: rtl/memory.sv
// Y86-64 memory stage: byte-addressed data memory with 64-bit LE access.
// Ports: clk, rst_n (sync, active-low), icode, valA, valE, valP -> valM, data_memory_error.
module memory #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic        data_memory_error
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [7:0]    mem [MEM_BYTES];
    logic          rd;
    logic          wr;
    logic          use_a;
    logic [63:0]   wdata;
    logic [63:0]   addr;
    logic          valid;
    logic [AW-1:0] base;

    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        use_a = 1'b0;
        wdata = valA;
        unique case (icode)
            I_RMMOVQ, I_PUSHQ: wr = 1'b1;
            I_MRMOVQ:          rd = 1'b1;
            I_CALL: begin
                wr    = 1'b1;
                wdata = valP;
            end
            I_RET, I_POPQ: begin
                rd    = 1'b1;
                use_a = 1'b1;
            end
            default: ;
        endcase
    end

    // Comparing against the last legal base avoids computing addr+7,
    // which could wrap for addresses near 2^64.
    assign addr  = use_a ? valA : valE;
    assign valid = (addr <= LAST);
    assign base  = valid ? addr[AW-1:0] : '0;

    assign data_memory_error = (rd | wr) & ~valid;

    always_comb begin
        valM = '0;
        if (rd && valid) begin
            for (int i = 0; i < 8; i++) begin
                valM[8*i +: 8] = mem[base + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr && valid) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Testbench for the Y86-64 memory stage: directed vector table,
// reset sequence, then random ops against a byte-array reference model.
module tb_memory;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic [63:0] valM;
    logic        data_memory_error;

    memory #(.MEM_BYTES(MB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .icode(icode),
        .valA(valA),
        .valE(valE),
        .valP(valP),
        .valM(valM),
        .data_memory_error(data_memory_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] a;
        logic [63:0] e;
        logic [63:0] p;
        logic [63:0] m;
        logic        err;
        logic        chk_m;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] got_m;
    logic        got_err;
    logic [7:0]  ref_mem [MB];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] ic,
                         input logic [63:0] a, input logic [63:0] e, input logic [63:0] p);
        @(negedge clk);
        rst_n = r;
        icode = ic;
        valA  = a;
        valE  = e;
        valP  = p;
        #1;
        got_m   = valM;
        got_err = data_memory_error;
    endtask

    function automatic logic [63:0] mread(input logic [63:0] ad);
        logic [63:0] v = 0;
        for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[int'(ad) + i]) << (8 * i));
        return v;
    endfunction

    function automatic logic [63:0] rnd_addr();
        int mode = $urandom_range(0, 9);
        if (mode <= 6) return 64'($urandom_range(0, MB - 1));
        if (mode == 7) return 64'(MB - 16 + $urandom_range(0, 15));
        if (mode == 8) return {$urandom, $urandom};
        return -64'($urandom_range(1, 100));
    endfunction

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{4'h4, 64'd20, 64'd50, 64'd0, 64'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'h5, 64'd0, 64'd50, 64'd0, 64'd20, 1'b0, 1'b1};
        tbl[2]  = '{4'h4, 64'd30, -64'd50, 64'd0, 64'd0, 1'b1, 1'b0};
        tbl[3]  = '{4'h5, 64'd0, -64'd50, 64'd0, 64'd0, 1'b1, 1'b1};
        tbl[4]  = '{4'h9, 64'd50, 64'd7, 64'd0, 64'd20, 1'b0, 1'b1};
        tbl[5]  = '{4'hB, 64'd50, 64'd900, 64'd0, 64'd20, 1'b0, 1'b1};
        tbl[6]  = '{4'h8, 64'd5, 64'd100, 64'd70, 64'd0, 1'b0, 1'b0};
        tbl[7]  = '{4'h5, 64'd0, 64'd100, 64'd0, 64'd70, 1'b0, 1'b1};
        tbl[8]  = '{4'hA, 64'h0123456789ABCDEF, 64'd200, 64'd0, 64'd0, 1'b0, 1'b0};
        tbl[9]  = '{4'h5, 64'd0, 64'd193, 64'd0, 64'hEF00000000000000, 1'b0, 1'b1};
        tbl[10] = '{4'h5, 64'd0, 64'd200, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1'b1};
        tbl[11] = '{4'h4, 64'h1122334455667788, 64'(MB - 8), 64'd0, 64'd0, 1'b0, 1'b0};
        tbl[12] = '{4'h5, 64'd0, 64'(MB - 8), 64'd0, 64'h1122334455667788, 1'b0, 1'b1};
        tbl[13] = '{4'h4, 64'hDEAD, 64'(MB - 7), 64'd0, 64'd0, 1'b1, 1'b0};
        tbl[14] = '{4'h5, 64'd0, 64'(MB - 7), 64'd0, 64'd0, 1'b1, 1'b1};
        tbl[15] = '{4'h4, 64'hBEEF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 1'b1, 1'b0};
        tbl[16] = '{4'h5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 1'b1, 1'b1};
        tbl[17] = '{4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1};
        tbl[18] = '{4'h1, 64'd999, 64'd50, 64'd1, 64'd0, 1'b0, 1'b1};
        tbl[19] = '{4'h6, 64'd999, 64'd50, 64'd1, 64'd0, 1'b0, 1'b1};
        tbl[20] = '{4'h7, 64'd50, -64'd3, 64'd1, 64'd0, 1'b0, 1'b1};
        tbl[21] = '{4'h5, 64'd0, 64'd50, 64'd0, 64'd20, 1'b0, 1'b1};

        rst_n = 1'b0;
        icode = 4'h0;
        valA  = '0;
        valE  = '0;
        valP  = '0;
        repeat (2) @(posedge clk);

        drive(1'b1, 4'h5, 64'd50, 64'd50, 64'd0);
        chk("reset_valM", got_m, 64'd0);
        chk("reset_err", 64'(got_err), 64'd0);

        for (int i = 0; i < 22; i++) begin
            drive(1'b1, tbl[i].ic, tbl[i].a, tbl[i].e, tbl[i].p);
            chk($sformatf("tbl%0d_err", i), 64'(got_err), 64'(tbl[i].err));
            if (tbl[i].chk_m) chk($sformatf("tbl%0d_valM", i), got_m, tbl[i].m);
        end

        // Reset with a concurrent write: write must be suppressed.
        drive(1'b0, 4'h4, 64'd77, 64'd300, 64'd0);
        drive(1'b1, 4'h5, 64'd0, 64'd50, 64'd0);
        chk("rst_clr_50", got_m, 64'd0);
        drive(1'b1, 4'h5, 64'd0, 64'd100, 64'd0);
        chk("rst_clr_100", got_m, 64'd0);
        drive(1'b1, 4'hB, 64'd200, 64'd0, 64'd0);
        chk("rst_clr_200", got_m, 64'd0);
        drive(1'b1, 4'h5, 64'd0, 64'(MB - 8), 64'd0);
        chk("rst_clr_top", got_m, 64'd0);
        drive(1'b1, 4'h5, 64'd0, 64'd300, 64'd0);
        chk("rst_no_write", got_m, 64'd0);

        for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;

        for (int k = 0; k < 600; k++) begin
            logic        r;
            logic [3:0]  ic;
            logic [63:0] a, e, p, ad, wd, em;
            logic        is_rd, is_wr, ok, ee;
            r  = ($urandom_range(0, 79) != 0);
            ic = 4'($urandom_range(0, 15));
            a  = rnd_addr();
            e  = rnd_addr();
            p  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0 && ic inside {4'h4, 4'hA}) a = {$urandom, $urandom};
            drive(r, ic, a, e, p);

            is_rd = ic inside {4'h5, 4'h9, 4'hB};
            is_wr = ic inside {4'h4, 4'h8, 4'hA};
            ad    = (ic inside {4'h9, 4'hB}) ? a : e;
            wd    = (ic == 4'h8) ? p : a;
            ok    = (ad <= 64'(MB - 8));
            ee    = (is_rd || is_wr) && !ok;
            em    = (is_rd && ok) ? mread(ad) : 64'd0;

            chk($sformatf("rnd%0d_err", k), 64'(got_err), 64'(ee));
            if (!is_wr) chk($sformatf("rnd%0d_valM", k), got_m, em);

            if (!r) begin
                for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
            end else if (is_wr && ok) begin
                for (int i = 0; i < 8; i++) ref_mem[int'(ad) + i] = wd[8*i +: 8];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
